// File: rtl/rf_half_writeback.sv
// Write-side sequencer for the half-width register file: buffers up to two 32-bit
// writeback results and retires each as a low-then-high pair of 16-bit half writes.
module rf_half_writeback #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic        rw_clken,
  output logic        rw_half,
  output logic [4:0]  rw_rd,
  output logic [15:0] rw_result,
  input  logic [4:0]  de_rs,
  output logic        hz_stall,
  output logic        idle
);

  logic [1:0]  count_q, count_d;
  logic        ph_q, ph_d;
  logic        hd_q, hd_d;
  logic [4:0]  rd_mem  [2];
  logic [31:0] res_mem [2];

  logic busy, push, pop, wr_idx;
  logic head_hit, tail_hit, wb_hit;

  assign busy     = (count_q != 2'd0);
  assign wb_ready = (count_q != 2'(DEPTH));
  assign idle     = ~busy;
  // x0 results are accepted on the handshake but never stored.
  assign push     = wb_valid & wb_ready & (wb_rd != 5'd0);
  assign pop      = busy & ph_q;
  // With two slots the free slot is the head when empty, the other one otherwise.
  assign wr_idx   = hd_q ^ count_q[0];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    ph_d = busy ? ~ph_q : 1'b0;
    hd_d = pop ? ~hd_q : hd_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      ph_q    <= 1'b0;
      hd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ph_q    <= ph_d;
      hd_q    <= hd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_idx]  <= wb_rd;
      res_mem[wr_idx] <= wb_result;
    end
  end

  always_comb begin
    rw_clken  = 1'b0;
    rw_half   = 1'b0;
    rw_rd     = 5'd0;
    rw_result = 16'd0;
    if (busy) begin
      rw_clken  = 1'b1;
      rw_half   = ph_q;
      rw_rd     = rd_mem[hd_q];
      rw_result = ph_q ? res_mem[hd_q][31:16] : res_mem[hd_q][15:0];
    end
  end

  // The head keeps matching until its high half has been written.
  assign head_hit = busy && (rd_mem[hd_q] == de_rs);
  assign tail_hit = (count_q == 2'd2) && (rd_mem[~hd_q] == de_rs);
  assign wb_hit   = wb_valid && wb_ready && (wb_rd == de_rs);
  assign hz_stall = (de_rs != 5'd0) && (head_hit || tail_hit || wb_hit);

endmodule
